// File: rtl/gpu_buf_pkg.sv
// Shared types and constants for the ping-pong frame buffer swap control.
package gpu_buf_pkg;

    // Sequencer states of the swap controller
    typedef enum logic [1:0] {
        RENDER    = 2'd0,
        WAIT_SCAN = 2'd1,
        FLIP      = 2'd2,
        CLEAR     = 2'd3
    } swap_state_t;

    // Width of the issued-flip counter; wraps naturally
    localparam int FRAME_CNT_W = 16;

endpackage

// File: rtl/clear_addr_gen.sv
// Step counter and per-channel address generator for the post-flip buffer clear.
// A start pulse launches SIZE/CHANNELS steps; done is high during the last step.
module clear_addr_gen #(
    parameter int CHANNELS  = 1,
    parameter int ADDR_SIZE = 8,
    parameter int SIZE      = 256
) (
    input  logic                          clk,
    input  logic                          n_rst,
    input  logic                          start,
    output logic                          done,
    output logic [ADDR_SIZE*CHANNELS-1:0] addr
);

    localparam int STEPS  = SIZE / CHANNELS;
    localparam int STEP_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [STEP_W-1:0] LAST = STEP_W'(STEPS - 1);

    logic              busy;
    logic [STEP_W-1:0] step;

    // Run the step counter from start until the last step has been issued
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            busy <= 1'b0;
            step <= '0;
        end else if (start) begin
            busy <= 1'b1;
            step <= '0;
        end else if (busy) begin
            if (step == LAST) begin
                busy <= 1'b0;
                step <= '0;
            end else begin
                step <= step + STEP_W'(1);
            end
        end
    end

    assign done = busy && (step == LAST);

    // Channel c covers word k*CHANNELS+c so all channels together sweep the buffer
    for (genvar c = 0; c < CHANNELS; c++) begin : g_addr
        assign addr[c*ADDR_SIZE +: ADDR_SIZE] =
            ADDR_SIZE'(step) * ADDR_SIZE'(CHANNELS) + ADDR_SIZE'(c);
    end

endmodule

// File: rtl/double_buffer_swap_ctrl.sv
// Ping-pong SRAM swap sequencer: flips only once the renderer has finished its
// frame and scanout has finished its read pass, optionally clears the new
// write buffer, and gates renderer writes while the swap is in progress.
module double_buffer_swap_ctrl
    import gpu_buf_pkg::*;
#(
    parameter int CHANNELS  = 1,
    parameter int ADDR_SIZE = 8,
    parameter int DATA_SIZE = 1,
    parameter int SIZE      = 256
) (
    input  logic                          clk,
    input  logic                          n_rst,
    input  logic                          render_done,
    input  logic                          scan_done,
    input  logic                          clear_en,
    input  logic [DATA_SIZE-1:0]          clear_value,
    input  logic [CHANNELS-1:0]           wr_en_in,
    input  logic [ADDR_SIZE*CHANNELS-1:0] wr_addr_in,
    input  logic [DATA_SIZE*CHANNELS-1:0] wr_data_in,
    output logic [CHANNELS-1:0]           wr_en_out,
    output logic [ADDR_SIZE*CHANNELS-1:0] wr_addr_out,
    output logic [DATA_SIZE*CHANNELS-1:0] wr_data_out,
    output logic                          flip,
    output logic                          write_buffer,
    output logic                          render_ready,
    output logic [FRAME_CNT_W-1:0]        frame_count,
    output logic                          proto_err
);

    swap_state_t                   state;
    swap_state_t                   state_nxt;
    logic                          scan_seen;
    logic                          clr_start;
    logic                          clr_done;
    logic [ADDR_SIZE*CHANNELS-1:0] clr_addr;

    assign clr_start = (state == FLIP) && clear_en;

    clear_addr_gen #(
        .CHANNELS  (CHANNELS),
        .ADDR_SIZE (ADDR_SIZE),
        .SIZE      (SIZE)
    ) u_clear_addr_gen (
        .clk   (clk),
        .n_rst (n_rst),
        .start (clr_start),
        .done  (clr_done),
        .addr  (clr_addr)
    );

    // Next-state decision: flip needs both frame done and scan done (now or remembered)
    always_comb begin
        state_nxt = state;
        unique case (state)
            RENDER: begin
                if (render_done) begin
                    state_nxt = (scan_seen || scan_done) ? FLIP : WAIT_SCAN;
                end
            end
            WAIT_SCAN: begin
                if (scan_done) begin
                    state_nxt = FLIP;
                end
            end
            FLIP: begin
                state_nxt = clear_en ? CLEAR : RENDER;
            end
            CLEAR: begin
                if (clr_done) begin
                    state_nxt = RENDER;
                end
            end
            default: state_nxt = RENDER;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= RENDER;
        end else begin
            state <= state_nxt;
        end
    end

    // Remember a scan completion until the flip consumes it; a pulse landing on the
    // flip cycle itself belongs to the next frame, so it survives the clear
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            scan_seen <= 1'b0;
        end else if (state == FLIP) begin
            scan_seen <= scan_done;
        end else if (state != WAIT_SCAN && scan_done) begin
            scan_seen <= 1'b1;
        end
    end

    // Buffer select shadow and flip counter advance at the end of the flip cycle
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            write_buffer <= 1'b0;
            frame_count  <= '0;
        end else if (state == FLIP) begin
            write_buffer <= ~write_buffer;
            frame_count  <= frame_count + FRAME_CNT_W'(1);
        end
    end

    // Sticky protocol error: renderer claimed frame done while it was not admitted
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            proto_err <= 1'b0;
        end else if (render_done && state != RENDER) begin
            proto_err <= 1'b1;
        end
    end

    // Write-port mux: renderer passes through in RENDER, clear engine owns CLEAR
    always_comb begin
        render_ready = (state == RENDER);
        flip         = (state == FLIP);
        wr_en_out    = '0;
        wr_addr_out  = '0;
        wr_data_out  = '0;
        if (state == RENDER) begin
            wr_en_out   = wr_en_in;
            wr_addr_out = wr_addr_in;
            wr_data_out = wr_data_in;
        end else if (state == CLEAR) begin
            wr_en_out   = '1;
            wr_addr_out = clr_addr;
            wr_data_out = {CHANNELS{clear_value}};
        end
    end

endmodule

// File: tb/tb_double_buffer_swap_ctrl.sv
// Bench for double_buffer_swap_ctrl: directed scenarios with literal expectations
// followed by randomized traffic, all checked against a frame-level model.
module tb_double_buffer_swap_ctrl;

    localparam int CH    = 2;
    localparam int SZ    = 8;
    localparam int AW    = 3;
    localparam int DW    = 4;
    localparam int STEPS = SZ / CH;

    logic              clk = 1'b0;
    logic              n_rst;
    logic              render_done, scan_done, clear_en;
    logic [DW-1:0]     clear_value;
    logic [CH-1:0]     wr_en_in;
    logic [AW*CH-1:0]  wr_addr_in;
    logic [DW*CH-1:0]  wr_data_in;
    logic [CH-1:0]     wr_en_out;
    logic [AW*CH-1:0]  wr_addr_out;
    logic [DW*CH-1:0]  wr_data_out;
    logic              flip, write_buffer, render_ready, proto_err;
    logic [15:0]       frame_count;

    int n_tests = 0;
    int n_fail  = 0;

    double_buffer_swap_ctrl #(
        .CHANNELS(CH), .ADDR_SIZE(AW), .DATA_SIZE(DW), .SIZE(SZ)
    ) dut (
        .clk(clk), .n_rst(n_rst),
        .render_done(render_done), .scan_done(scan_done),
        .clear_en(clear_en), .clear_value(clear_value),
        .wr_en_in(wr_en_in), .wr_addr_in(wr_addr_in), .wr_data_in(wr_data_in),
        .wr_en_out(wr_en_out), .wr_addr_out(wr_addr_out), .wr_data_out(wr_data_out),
        .flip(flip), .write_buffer(write_buffer), .render_ready(render_ready),
        .frame_count(frame_count), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h, expected %0h", nm, $time, act, exp);
        end
    endtask

    // Frame-level model: the renderer is either admitted, waiting on scanout,
    // on its flip cycle, or has some number of clear cycles still to run.
    bit          m_waiting;
    bit          m_flipping;
    int          m_clr_left;
    bit          m_seen;
    bit          m_wb;
    int          m_frames;
    bit          m_err;
    logic [DW-1:0] mem [2][SZ];

    bit            e_ready;
    logic [CH-1:0] e_en;
    int            e_step;

    always @(negedge clk) begin
        if (!n_rst) begin
            m_waiting  = 0;
            m_flipping = 0;
            m_clr_left = 0;
            m_seen     = 0;
            m_wb       = 0;
            m_frames   = 0;
            m_err      = 0;
            for (int b = 0; b < 2; b++)
                for (int i = 0; i < SZ; i++) mem[b][i] = '0;
        end
        e_ready = !m_waiting && !m_flipping && (m_clr_left == 0);
        e_step  = STEPS - m_clr_left;
        e_en    = e_ready ? wr_en_in : ((m_clr_left > 0) ? '1 : '0);
        chk("render_ready", 32'(render_ready), 32'(e_ready));
        chk("flip", 32'(flip), 32'(m_flipping));
        chk("write_buffer", 32'(write_buffer), 32'(m_wb));
        chk("frame_count", 32'(frame_count), 32'(m_frames % 65536));
        chk("proto_err", 32'(proto_err), 32'(m_err));
        chk("wr_en_out", 32'(wr_en_out), 32'(e_en));
        for (int c = 0; c < CH; c++) begin
            if (e_en[c]) begin
                chk("wr_addr_out", 32'(wr_addr_out[c*AW +: AW]),
                    e_ready ? 32'(wr_addr_in[c*AW +: AW]) : 32'(e_step * CH + c));
                chk("wr_data_out", 32'(wr_data_out[c*DW +: DW]),
                    e_ready ? 32'(wr_data_in[c*DW +: DW]) : 32'(clear_value));
            end
            // SRAM image fed from what the DUT actually drives
            if (wr_en_out[c])
                mem[write_buffer][wr_addr_out[c*AW +: AW]] = wr_data_out[c*DW +: DW];
        end
        if (n_rst) begin
            if (m_flipping) begin
                m_flipping = 0;
                m_wb       = !m_wb;
                m_frames   = m_frames + 1;
                m_seen     = scan_done;
                m_clr_left = clear_en ? STEPS : 0;
                if (render_done) m_err = 1;
            end else if (m_clr_left > 0) begin
                m_clr_left = m_clr_left - 1;
                if (scan_done) m_seen = 1;
                if (render_done) m_err = 1;
            end else if (m_waiting) begin
                if (scan_done) begin
                    m_waiting  = 0;
                    m_flipping = 1;
                end
                if (render_done) m_err = 1;
            end else begin
                if (render_done) begin
                    if (m_seen || scan_done) m_flipping = 1;
                    else m_waiting = 1;
                end
                if (scan_done) m_seen = 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
        render_done = 1'b0;
        scan_done   = 1'b0;
    endtask

    initial begin
        n_rst = 1'b0; render_done = 0; scan_done = 0; clear_en = 0;
        clear_value = '0; wr_en_in = '0; wr_addr_in = '0; wr_data_in = '0;

        // Reset with no stimulus
        @(negedge clk);
        chk("rst_ready", 32'(render_ready), 32'd1);
        chk("rst_flip", 32'(flip), 32'd0);
        chk("rst_wb", 32'(write_buffer), 32'd0);
        chk("rst_fc", 32'(frame_count), 32'd0);
        repeat (2) tick();
        n_rst = 1'b1;

        // Scan done early, render done later, no clear
        scan_done = 1'b1;
        tick();
        repeat (4) tick();
        render_done = 1'b1;
        @(negedge clk);
        chk("t2_preflip", 32'(flip), 32'd0);
        tick();
        @(negedge clk);
        chk("t2_flip", 32'(flip), 32'd1);
        tick();
        @(negedge clk);
        chk("t2_flip_end", 32'(flip), 32'd0);
        chk("t2_wb", 32'(write_buffer), 32'd1);
        chk("t2_ready", 32'(render_ready), 32'd1);
        chk("t2_fc", 32'(frame_count), 32'd1);

        // Render done first, scanout late: renderer writes blocked meanwhile
        render_done = 1'b1;
        tick();
        wr_en_in = 2'b11; wr_addr_in = 6'o52; wr_data_in = 8'h3C;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t3_ready", 32'(render_ready), 32'd0);
            chk("t3_blocked", 32'(wr_en_out), 32'd0);
            tick();
        end
        scan_done = 1'b1;
        tick();
        @(negedge clk);
        chk("t3_flip", 32'(flip), 32'd1);
        chk("t3_flip_blocked", 32'(wr_en_out), 32'd0);
        tick();
        wr_en_in = '0;
        @(negedge clk);
        chk("t3_wb", 32'(write_buffer), 32'd0);
        chk("t3_fc", 32'(frame_count), 32'd2);

        // Simultaneous done pulses with clear to 4'hA
        render_done = 1'b1; scan_done = 1'b1; clear_en = 1'b1; clear_value = 4'hA;
        tick();
        @(negedge clk);
        chk("t4_flip", 32'(flip), 32'd1);
        tick();
        clear_en = 1'b0;
        for (int k = 0; k < STEPS; k++) begin
            @(negedge clk);
            chk("t4_clr_en", 32'(wr_en_out), 32'h3);
            chk("t4_addr0", 32'(wr_addr_out[2:0]), 32'(2 * k));
            chk("t4_addr1", 32'(wr_addr_out[5:3]), 32'(2 * k + 1));
            chk("t4_data", 32'(wr_data_out), 32'hAA);
            tick();
        end
        @(negedge clk);
        chk("t4_ready", 32'(render_ready), 32'd1);
        for (int i = 0; i < SZ; i++) chk("t4_mem", 32'(mem[1][i]), 32'hA);

        // Reset during clear step 2, then a protocol violation
        render_done = 1'b1; scan_done = 1'b1; clear_en = 1'b1; clear_value = 4'h5;
        tick();
        tick();
        clear_en = 1'b0;
        tick();
        tick();
        n_rst = 1'b0;
        @(negedge clk);
        chk("t5_ready", 32'(render_ready), 32'd1);
        chk("t5_wb", 32'(write_buffer), 32'd0);
        chk("t5_fc", 32'(frame_count), 32'd0);
        chk("t5_en", 32'(wr_en_out), 32'd0);
        tick();
        n_rst = 1'b1;
        render_done = 1'b1;
        tick();
        render_done = 1'b1;
        @(negedge clk);
        chk("t5_err_pre", 32'(proto_err), 32'd0);
        tick();
        @(negedge clk);
        chk("t5_err", 32'(proto_err), 32'd1);
        scan_done = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        chk("t5_err_sticky", 32'(proto_err), 32'd1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            tick();
            if ($urandom_range(0, 399) == 0) begin
                n_rst = 1'b0; wr_en_in = '0;
                tick();
                n_rst = 1'b1;
            end
            render_done = ($urandom_range(0, 7) == 0);
            scan_done   = ($urandom_range(0, 5) == 0);
            clear_en    = $urandom_range(0, 1) == 1;
            clear_value = DW'($urandom);
            wr_en_in    = CH'($urandom);
            wr_addr_in  = (AW*CH)'($urandom);
            wr_data_in  = (DW*CH)'($urandom);
        end
        tick();
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
